simon_round_ctrl: RTL and testbench
===================================

SIMON_ROUND_CTRL -- requirements
Module: simon_round_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, word width in bits.
REQ-002 SHALL have parameter M, default 4, key words.
REQ-003 SHALL have parameter T, default 32, rounds; legal range 4..64.
REQ-004 SHALL have parameter CW, default 5, round/address counter width; CW = clog2(T).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 nR  in  1  reset, synchronous, active-low.
REQ-007 newKEY  in  1  key words present on input stage.
REQ-008 newDATA  in  1  data block present on input stage.
REQ-009 dec  in  1  1 = decrypt; sampled only in DLOAD.
REQ-010 outREADY  in  1  output stage accepts result.
REQ-011 loadKEY  out  1  key consumed strobe to input stage.
REQ-012 loadDATA  out  1  block consumed strobe to input stage.
REQ-013 keyLOAD  out  1  load key-schedule register from KEY.
REQ-014 keyWR  out  1  write current schedule word to round-key store.
REQ-015 dataLOAD  out  1  load round-state register from inDATA.
REQ-016 roundEN  out  1  advance round function one round.
REQ-017 keyADDR  out  CW  round-key store address.
REQ-018 keyVALID  out  1  round-key store fully written.
REQ-019 outVALID  out  1  result valid in round-state register.
REQ-020 busy  out  1  state != IDLE.
REQ-021 blkCOUNT  out  8  blocks delivered count.

Function
REQ-022 SHALL implement states IDLE, KLOAD, KEXP, DLOAD, ROUND, DONE with a CW-bit counter cnt; all outputs decoded from registered state/cnt (no input-to-output combinational path).
REQ-023 IDLE: newKEY=1 -> KLOAD; else newDATA=1 && keyVALID=1 -> DLOAD; else stay. newKEY wins when both high.
REQ-024 newDATA with keyVALID=0 SHALL be held off: stay IDLE, loadDATA=0.
REQ-025 KLOAD (1 cycle): loadKEY=1, keyLOAD=1, keyVALID cleared, cnt<=0 -> KEXP.
REQ-026 KEXP (T cycles): keyWR=1, keyADDR=cnt, cnt increments; at cnt=T-1 set keyVALID=1, cnt<=0 -> IDLE.
REQ-027 DLOAD (1 cycle): loadDATA=1, dataLOAD=1, dec latched, cnt<=0 -> ROUND.
REQ-028 ROUND (T cycles): roundEN=1, keyADDR = cnt if dec latched 0, T-1-cnt if 1; at cnt=T-1 -> DONE.
REQ-029 DONE: outVALID=1 held until outREADY=1 sampled; on that edge blkCOUNT increments (255 wraps to 0) -> IDLE.
REQ-030 Latency: newDATA sampled in IDLE at edge k -> DLOAD cycle k+1, ROUND cycles k+2..k+T+1, outVALID from k+T+2.
REQ-031 newKEY arriving in DLOAD/ROUND/DONE SHALL be ignored until IDLE; current block completes with old keys.
REQ-032 loadKEY, loadDATA, keyLOAD, dataLOAD SHALL be single-cycle pulses, one per transaction.
REQ-033 newKEY/newDATA changes outside IDLE SHALL have no effect.
REQ-034 keyADDR SHALL be 0 in IDLE, KLOAD, DLOAD, DONE.

Reset
REQ-035 nR=0 at a rising edge SHALL force IDLE, cnt=0, keyVALID=0, blkCOUNT=0, latched dec=0, all strobes 0, outVALID=0, busy=0, from any state.
REQ-036 Reset mid-KEXP/ROUND SHALL abandon the operation; keyVALID stays 0 until a full KEXP completes.

Verification
REQ-037 Reset, newKEY=1 one cycle -> loadKEY/keyLOAD pulse at cycle 1, keyWR=1 cycles 2..33 with keyADDR 0..31, keyVALID=1 from cycle 34.
REQ-038 keyVALID=1, newDATA=1, dec=0, outREADY=1 -> loadDATA at k+1, keyADDR 0..31 during roundEN, outVALID at k+34, blkCOUNT=1.
REQ-039 Same with dec=1 -> keyADDR 31..0 during ROUND.
REQ-040 newDATA=1 before any key -> no loadDATA for 50 cycles; then newKEY -> KEXP runs, then block accepted.
REQ-041 outREADY=0 for 10 cycles in DONE -> outVALID held, blkCOUNT unchanged; newKEY meanwhile ignored until IDLE; blkCOUNT 255 -> 0 on wrap.
REQ-042 nR=0 at ROUND cnt=15 -> next edge IDLE, all outputs 0, keyVALID=0.

Source files
------------

// File: rtl/simon_round_ctrl.sv
// Sequencing controller for a SIMON block cipher: key expansion into the
// round-key store, then per-block round iteration with forward/reverse key order.
module simon_round_ctrl #(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int T  = 32,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          nR,
    input  logic          newKEY,
    input  logic          newDATA,
    input  logic          dec,
    input  logic          outREADY,
    output logic          loadKEY,
    output logic          loadDATA,
    output logic          keyLOAD,
    output logic          keyWR,
    output logic          dataLOAD,
    output logic          roundEN,
    output logic [CW-1:0] keyADDR,
    output logic          keyVALID,
    output logic          outVALID,
    output logic          busy,
    output logic [7:0]    blkCOUNT
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KLOAD = 3'd1,
        KEXP  = 3'd2,
        DLOAD = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(T - 1);

    generate
        if (T < 4 || T > 64 || CW != $clog2(T) || N < 1 || M < 1) begin : g_bad_params
            $error("simon_round_ctrl: illegal parameter combination");
        end
    endgenerate

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          key_valid_reg, key_valid_next;
    logic          dec_reg, dec_next;
    logic [7:0]    blk_count_reg, blk_count_next;

    always_ff @(posedge clk) begin
        if (!nR) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            key_valid_reg <= 1'b0;
            dec_reg       <= 1'b0;
            blk_count_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            key_valid_reg <= key_valid_next;
            dec_reg       <= dec_next;
            blk_count_reg <= blk_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        key_valid_next = key_valid_reg;
        dec_next       = dec_reg;
        blk_count_next = blk_count_reg;
        case (state_reg)
            IDLE: begin
                // A new key always takes priority over a pending data block.
                if (newKEY)
                    state_next = KLOAD;
                else if (newDATA && key_valid_reg)
                    state_next = DLOAD;
            end
            KLOAD: begin
                key_valid_next = 1'b0;
                cnt_next       = '0;
                state_next     = KEXP;
            end
            KEXP: begin
                if (cnt_reg == CNT_LAST) begin
                    key_valid_next = 1'b1;
                    cnt_next       = '0;
                    state_next     = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DLOAD: begin
                dec_next   = dec;
                cnt_next   = '0;
                state_next = ROUND;
            end
            ROUND: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (outREADY) begin
                    blk_count_next = blk_count_reg + 8'd1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Every output is decoded from registered state only.
    always_comb begin
        loadKEY  = (state_reg == KLOAD);
        keyLOAD  = (state_reg == KLOAD);
        keyWR    = (state_reg == KEXP);
        loadDATA = (state_reg == DLOAD);
        dataLOAD = (state_reg == DLOAD);
        roundEN  = (state_reg == ROUND);
        outVALID = (state_reg == DONE);
        busy     = (state_reg != IDLE);
        keyADDR  = '0;
        if (state_reg == KEXP)
            keyADDR = cnt_reg;
        else if (state_reg == ROUND)
            keyADDR = dec_reg ? (CNT_LAST - cnt_reg) : cnt_reg;
    end

    assign keyVALID = key_valid_reg;
    assign blkCOUNT = blk_count_reg;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Vector-driven bench for simon_round_ctrl: each record is one clock of inputs
// plus the outputs expected just after that edge.
module tb_simon_round_ctrl;

    logic       clk = 1'b0;
    logic       nR, newKEY, newDATA, dec, outREADY;
    logic       loadKEY, loadDATA, keyLOAD, keyWR, dataLOAD, roundEN;
    logic [4:0] keyADDR;
    logic       keyVALID, outVALID, busy;
    logic [7:0] blkCOUNT;

    always #5 clk = ~clk;

    simon_round_ctrl dut (
        .clk(clk), .nR(nR), .newKEY(newKEY), .newDATA(newDATA), .dec(dec),
        .outREADY(outREADY), .loadKEY(loadKEY), .loadDATA(loadDATA),
        .keyLOAD(keyLOAD), .keyWR(keyWR), .dataLOAD(dataLOAD), .roundEN(roundEN),
        .keyADDR(keyADDR), .keyVALID(keyVALID), .outVALID(outVALID), .busy(busy),
        .blkCOUNT(blkCOUNT)
    );

    // Flag order: loadKEY keyLOAD keyWR keyVALID loadDATA dataLOAD roundEN outVALID busy
    localparam logic [8:0] F_IDLE0  = 9'b000000000;
    localparam logic [8:0] F_IDLE1  = 9'b000100000;
    localparam logic [8:0] F_KLOAD0 = 9'b110000001;
    localparam logic [8:0] F_KLOAD  = 9'b110000001;
    localparam logic [8:0] F_KEXP   = 9'b001000001;
    localparam logic [8:0] F_DLOAD  = 9'b000111001;
    localparam logic [8:0] F_ROUND  = 9'b000100101;
    localparam logic [8:0] F_DONE   = 9'b000100011;
    localparam logic [8:0] M_ALL    = 9'b111111111;
    localparam logic [8:0] M_NO_KV  = 9'b111011111;

    typedef struct {
        string      name;
        logic       nr, nk, nd, dc, rdy;
        logic [8:0] flags;
        logic [8:0] mask;
        logic [4:0] addr;
        logic [7:0] blk;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    logic [8:0] flags_obs;

    assign flags_obs = {loadKEY, keyLOAD, keyWR, keyVALID, loadDATA, dataLOAD,
                        roundEN, outVALID, busy};

    function automatic void push(string nm, logic nr_v, logic nk_v, logic nd_v,
                                 logic dc_v, logic rdy_v, logic [8:0] fl,
                                 logic [8:0] mk, logic [4:0] ad, logic [7:0] bk);
        vec_t v;
        v.name = nm; v.nr = nr_v; v.nk = nk_v; v.nd = nd_v; v.dc = dc_v; v.rdy = rdy_v;
        v.flags = fl; v.mask = mk; v.addr = ad; v.blk = bk;
        vq.push_back(v);
    endfunction

    // One full key expansion starting from IDLE with the key already presented.
    function automatic void add_key(logic [8:0] kload_mask, logic [7:0] bk, logic nd_v);
        push("kload", 1, 1, nd_v, 0, 0, F_KLOAD, kload_mask, 5'd0, bk);
        for (int i = 0; i < 32; i++)
            push("kexp", 1, 0, nd_v, 0, 0, F_KEXP, M_ALL, 5'(i), bk);
        push("key_done", 1, 0, nd_v, 0, 0, F_IDLE1, M_ALL, 5'd0, bk);
    endfunction

    // Block from IDLE up to the first DONE cycle; the latched direction is the
    // value of dec during DLOAD, and dec is then inverted to prove it is ignored.
    function automatic void add_rounds(logic dec_v, logic [7:0] bk, logic rdy_v, logic nk_v);
        push("dload", 1, 0, 1, 0, 0, F_DLOAD, M_ALL, 5'd0, bk);
        push("round", 1, 0, 0, dec_v, 0, F_ROUND, M_ALL, dec_v ? 5'd31 : 5'd0, bk);
        for (int i = 1; i < 32; i++)
            push("round", 1, 0, 0, ~dec_v, 0, F_ROUND, M_ALL,
                 dec_v ? 5'(31 - i) : 5'(i), bk);
        push("done", 1, nk_v, 0, 0, rdy_v, F_DONE, M_ALL, 5'd0, bk);
    endfunction

    function automatic void add_block(logic dec_v, logic [7:0] bk);
        add_rounds(dec_v, bk, 1'b1, 1'b0);
        push("out_taken", 1, 0, 0, 0, 1, F_IDLE1, M_ALL, 5'd0, bk + 8'd1);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(vec_t v);
        nR = v.nr; newKEY = v.nk; newDATA = v.nd; dec = v.dc; outREADY = v.rdy;
        @(posedge clk);
        #1;
        chk({v.name, ".flags"}, 32'(flags_obs & v.mask), 32'(v.flags & v.mask));
        chk({v.name, ".keyADDR"}, 32'(keyADDR), 32'(v.addr));
        chk({v.name, ".blkCOUNT"}, 32'(blkCOUNT), 32'(v.blk));
    endtask

    task automatic drain(string label);
        for (int i = 0; i < vq.size(); i++)
            apply(vq[i]);
        $display("txn %s: %0d cycles, blkCOUNT=%0d", label, vq.size(), blkCOUNT);
        vq.delete();
    endtask

    initial begin
        nR = 1'b0; newKEY = 1'b0; newDATA = 1'b0; dec = 1'b0; outREADY = 1'b0;
        #1;

        // Reset, data held off without a key, then key load and two blocks.
        push("reset", 0, 0, 0, 0, 0, F_IDLE0, M_ALL, 5'd0, 8'd0);
        for (int i = 0; i < 50; i++)
            push("hold_off", 1, 0, 1, 0, 0, F_IDLE0, M_ALL, 5'd0, 8'd0);
        add_key(M_ALL, 8'd0, 1'b1);
        add_block(1'b0, 8'd0);
        add_block(1'b1, 8'd1);
        drain("key_and_two_blocks");

        // Result held in DONE for 10 cycles while newKEY is asserted.
        add_rounds(1'b0, 8'd2, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            push("done_wait", 1, 1, 0, 0, 0, F_DONE, M_ALL, 5'd0, 8'd2);
        push("done_release", 1, 1, 0, 0, 1, F_IDLE1, M_ALL, 5'd0, 8'd3);
        add_key(M_NO_KV, 8'd3, 1'b0);
        drain("done_stall_then_rekey");

        // Run blkCOUNT through 255 and back to 0.
        for (int b = 3; b < 256; b++) begin
            add_block(b[0], 8'(b));
            drain("block");
        end
        add_block(1'b0, 8'd0);
        drain("post_wrap_block");

        // Reset in the middle of ROUND at cnt=15.
        push("dload", 1, 0, 1, 0, 0, F_DLOAD, M_ALL, 5'd0, 8'd1);
        for (int i = 0; i < 16; i++)
            push("round", 1, 0, 0, 0, 0, F_ROUND, M_ALL, 5'(i), 8'd1);
        push("mid_reset", 0, 0, 0, 0, 0, F_IDLE0, M_ALL, 5'd0, 8'd0);
        for (int i = 0; i < 3; i++)
            push("post_reset_hold", 1, 0, 1, 0, 0, F_IDLE0, M_ALL, 5'd0, 8'd0);
        drain("mid_round_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
